hazard_ctrl_p: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core: it generalises the fixed load-use and forwarding logic. It decides operand forwarding for EXE and the store-data path, and inserts load-use bubbles. It also runs a multi-cycle redirect-flush FSM, freezes the pipe on data-memory wait, implements debug single-step, and keeps saturating performance counters. It sits beside the ID-stage decoder and drives the per-stage enable/reset lines.

---
 rtl/hazard_ctrl_p.sv | 170 +++++++++++++++++
 tb/tb_hazard_ctrl_p.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_p.sv
// Pipeline hazard controller for the 5-stage core: operand forwarding, load-use bubbles,
// redirect-flush sequencing, memory-wait freeze, debug single-step and saturating event counters.
//
// state | meaning
// RUN   | normal issue; a taken redirect in an advancing cycle may start a flush
// FLUSH | ID is squashed for `rem` more advancing cycles
module hazard_ctrl_p #(
  parameter int ADDR_W      = 5,
  parameter int FLUSH_SLOTS = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_store,
  input  logic [ADDR_W-1:0] exe_regw_addr,
  input  logic [ADDR_W-1:0] mem_regw_addr,
  input  logic              exe_wb_wen,
  input  logic              mem_wb_wen,
  input  logic              exe_is_load,
  input  logic              mem_is_load,
  input  logic              redirect,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  input  logic              cnt_clr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_m,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              if_rst,
  output logic              id_rst,
  output logic              exe_rst,
  output logic              mem_rst,
  output logic              wb_rst,
  output logic [CNT_W-1:0]  load_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  mwait_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] SLOTS = 4'(FLUSH_SLOTS);

  state_t     state, state_nxt;
  logic [3:0] rem, rem_nxt;
  logic       step_q;

  logic       a_ok, a_exe, a_mem, haz_a;
  logic       b_ok, b_exe, b_mem, haz_b;
  logic [1:0] code_a, code_b;
  logic       store_fwd, load_stall_req;
  logic       mem_wait, step_edge, hold, advance;
  logic [4:0] en_vec, rst_vec;
  logic       stall_applied, flush_applied;

  always_comb begin
    a_ok   = id_rs_used && (id_rs_addr != '0);
    a_exe  = a_ok && exe_wb_wen && (id_rs_addr == exe_regw_addr);
    a_mem  = a_ok && mem_wb_wen && (id_rs_addr == mem_regw_addr);
    haz_a  = a_exe && exe_is_load;
    code_a = a_exe ? (exe_is_load ? 2'd0 : 2'd1)
           : a_mem ? (mem_is_load ? 2'd3 : 2'd2) : 2'd0;

    b_ok   = id_rt_used && (id_rt_addr != '0);
    b_exe  = b_ok && exe_wb_wen && (id_rt_addr == exe_regw_addr);
    b_mem  = b_ok && mem_wb_wen && (id_rt_addr == mem_regw_addr);
    haz_b  = b_exe && exe_is_load;
    code_b = b_exe ? (exe_is_load ? 2'd0 : 2'd1)
           : b_mem ? (mem_is_load ? 2'd3 : 2'd2) : 2'd0;

    // a store only needs rt in MEM, so it can pick the load data up there
    store_fwd      = haz_b && id_is_store;
    load_stall_req = haz_a || (haz_b && !id_is_store);
  end

  assign fwd_a = rst ? 2'd0 : code_a;
  assign fwd_b = rst ? 2'd0 : code_b;
  assign fwd_m = rst ? 1'b0 : store_fwd;

  assign mem_wait  = dmem_req && !dmem_ack;
  assign step_edge = debug_step && !step_q;
  assign hold      = debug_en && !step_edge;
  assign advance   = !mem_wait && !hold;

  // bit order {if, id, exe, mem, wb}; first matching cause wins
  always_comb begin
    en_vec        = 5'b11111;
    rst_vec       = 5'b00000;
    stall_applied = 1'b0;
    flush_applied = 1'b0;
    if (rst) begin
      rst_vec = 5'b11111;
    end else if (mem_wait || hold) begin
      en_vec = 5'b00000;
    end else if (state == FLUSH) begin
      rst_vec[3]    = 1'b1;
      flush_applied = 1'b1;
    end else if (load_stall_req) begin
      en_vec[4]     = 1'b0;
      en_vec[3]     = 1'b0;
      rst_vec[2]    = 1'b1;
      stall_applied = 1'b1;
    end
  end

  assign {if_en, id_en, exe_en, mem_en, wb_en}      = en_vec;
  assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = rst_vec;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    case (state)
      RUN: begin
        if (advance && !load_stall_req && redirect && (SLOTS != 4'd0)) begin
          state_nxt = FLUSH;
          rem_nxt   = SLOTS;
        end
      end
      FLUSH: begin
        if (advance) begin
          rem_nxt = rem - 4'd1;
          if (rem == 4'd1) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      rem    <= 4'd0;
      step_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      step_q <= debug_step;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_stall_cnt <= '0;
      flush_cnt      <= '0;
      mwait_cnt      <= '0;
    end else if (cnt_clr) begin
      load_stall_cnt <= '0;
      flush_cnt      <= '0;
      mwait_cnt      <= '0;
    end else begin
      if (stall_applied) load_stall_cnt <= sat_inc(load_stall_cnt);
      if (flush_applied) flush_cnt      <= sat_inc(flush_cnt);
      if (mem_wait)      mwait_cnt      <= sat_inc(mwait_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Directed bench for hazard_ctrl_p with FLUSH_SLOTS=2 and 4-bit counters; expected values
// are hand-computed per step.
module tb_hazard_ctrl_p;

  logic       clk, rst;
  logic       debug_en, debug_step;
  logic [4:0] id_rs_addr, id_rt_addr, exe_regw_addr, mem_regw_addr;
  logic       id_rs_used, id_rt_used, id_is_store;
  logic       exe_wb_wen, mem_wb_wen, exe_is_load, mem_is_load;
  logic       redirect, dmem_req, dmem_ack, cnt_clr;
  logic [1:0] fwd_a, fwd_b;
  logic       fwd_m;
  logic       if_en, id_en, exe_en, mem_en, wb_en;
  logic       if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic [3:0] load_stall_cnt, flush_cnt, mwait_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_ctrl_p #(.ADDR_W(5), .FLUSH_SLOTS(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_store(id_is_store),
    .exe_regw_addr(exe_regw_addr), .mem_regw_addr(mem_regw_addr),
    .exe_wb_wen(exe_wb_wen), .mem_wb_wen(mem_wb_wen),
    .exe_is_load(exe_is_load), .mem_is_load(mem_is_load),
    .redirect(redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack), .cnt_clr(cnt_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_m(fwd_m),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .load_stall_cnt(load_stall_cnt), .flush_cnt(flush_cnt), .mwait_cnt(mwait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [4:0] en_v  = {if_en, id_en, exe_en, mem_en, wb_en};
  wire [4:0] rst_v = {if_rst, id_rst, exe_rst, mem_rst, wb_rst};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change 2 time units after the rising edge, checks follow 1 unit later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_pipe();
    id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0; id_is_store = 0;
    exe_regw_addr = 0; mem_regw_addr = 0; exe_wb_wen = 0; mem_wb_wen = 0;
    exe_is_load = 0; mem_is_load = 0; redirect = 0;
  endtask

  initial begin
    rst = 1; debug_en = 0; debug_step = 1;
    dmem_req = 0; dmem_ack = 0; cnt_clr = 0;
    clear_pipe();
    // a forwarding match that must be masked while in reset
    id_rs_used = 1; id_rs_addr = 2; exe_regw_addr = 2; exe_wb_wen = 1;
    tick(); #1;
    chk("reset_rst", 16'(rst_v), 16'h1f);
    chk("reset_en", 16'(en_v), 16'h1f);
    chk("reset_fwd_a", 16'(fwd_a), 16'h0);
    chk("reset_cnt", 16'({load_stall_cnt, flush_cnt, mwait_cnt}), 16'h0);

    // debug: step held high through reset release must not fire
    clear_pipe();
    rst = 0; debug_en = 1; #1;
    chk("dbg_release_hold", 16'(en_v), 16'h00);
    chk("dbg_release_rst", 16'(rst_v), 16'h00);
    tick(); #1;
    chk("dbg_held_high", 16'(en_v), 16'h00);
    debug_step = 0;
    tick();
    debug_step = 1; #1;
    chk("dbg_step_edge", 16'(en_v), 16'h1f);
    tick(); #1;
    chk("dbg_step_held", 16'(en_v), 16'h00);
    tick();
    debug_step = 0; #1;
    chk("dbg_step_low", 16'(en_v), 16'h00);
    debug_en = 0; #1;
    chk("dbg_off", 16'(en_v), 16'h1f);

    // lw $2 in EXE, add $3,$2,$2 in ID
    tick();
    exe_regw_addr = 2; exe_wb_wen = 1; exe_is_load = 1;
    id_rs_addr = 2; id_rt_addr = 2; id_rs_used = 1; id_rt_used = 1; #1;
    chk("lu_stall_en", 16'(en_v), 16'h07);
    chk("lu_stall_rst", 16'(rst_v), 16'h04);
    tick();
    exe_wb_wen = 0; exe_is_load = 0; exe_regw_addr = 0;
    mem_regw_addr = 2; mem_wb_wen = 1; mem_is_load = 1; #1;
    chk("lu_fwd_a", 16'(fwd_a), 16'h3);
    chk("lu_fwd_b", 16'(fwd_b), 16'h3);
    chk("lu_after_en", 16'(en_v), 16'h1f);
    chk("lu_stall_cnt", 16'(load_stall_cnt), 16'h1);

    // lw $2 in EXE, sw $2,0($4) in ID
    tick();
    clear_pipe();
    exe_regw_addr = 2; exe_wb_wen = 1; exe_is_load = 1;
    id_rs_addr = 4; id_rs_used = 1; id_rt_addr = 2; id_rt_used = 1; id_is_store = 1; #1;
    chk("st_fwd_m", 16'(fwd_m), 16'h1);
    chk("st_fwd_b", 16'(fwd_b), 16'h0);
    chk("st_fwd_a", 16'(fwd_a), 16'h0);
    chk("st_no_stall", 16'(en_v), 16'h1f);
    tick(); #1;
    chk("st_stall_cnt", 16'(load_stall_cnt), 16'h1);

    // EXE ALU result beats MEM; MEM ALU gives 2; $0 and unused never forward
    clear_pipe();
    exe_regw_addr = 5; exe_wb_wen = 1; mem_regw_addr = 5; mem_wb_wen = 1;
    id_rs_addr = 5; id_rs_used = 1; #1;
    chk("prio_exe", 16'(fwd_a), 16'h1);
    exe_regw_addr = 7; id_rt_addr = 5; id_rt_used = 1; #1;
    chk("mem_alu", 16'(fwd_b), 16'h2);
    id_rt_used = 0; #1;
    chk("unused_rt", 16'(fwd_b), 16'h0);
    exe_regw_addr = 0; mem_regw_addr = 0; id_rs_addr = 0; #1;
    chk("zero_reg", 16'(fwd_a), 16'h0);

    // redirect at T; second redirect at T+1 must be ignored
    clear_pipe();
    redirect = 1; #1;
    chk("fl_T", 16'(rst_v), 16'h00);
    tick(); #1;
    chk("fl_T1", 16'(rst_v), 16'h08);
    tick();
    redirect = 0; #1;
    chk("fl_T2", 16'(rst_v), 16'h08);
    tick(); #1;
    chk("fl_T3", 16'(rst_v), 16'h00);
    chk("fl_cnt", 16'(flush_cnt), 16'h2);

    cnt_clr = 1;
    tick();
    cnt_clr = 0; #1;
    chk("clr_all", 16'({load_stall_cnt, flush_cnt, mwait_cnt}), 16'h0);

    // redirect then three memory-wait cycles stretching the flush window
    redirect = 1;
    tick();
    redirect = 0; dmem_req = 1; dmem_ack = 0; #1;
    chk("fw_wait1_en", 16'(en_v), 16'h00);
    chk("fw_wait1_rst", 16'(rst_v), 16'h00);
    tick(); #1;
    chk("fw_wait2_en", 16'(en_v), 16'h00);
    tick(); #1;
    chk("fw_wait3_en", 16'(en_v), 16'h00);
    tick();
    dmem_req = 0; #1;
    chk("fw_resume1", 16'(rst_v), 16'h08);
    chk("fw_resume1_en", 16'(en_v), 16'h1f);
    tick(); #1;
    chk("fw_resume2", 16'(rst_v), 16'h08);
    tick(); #1;
    chk("fw_done", 16'(rst_v), 16'h00);
    chk("fw_mwait_cnt", 16'(mwait_cnt), 16'h3);
    chk("fw_flush_cnt", 16'(flush_cnt), 16'h2);

    // 20 stall cycles saturate the 4-bit counter
    exe_regw_addr = 9; exe_wb_wen = 1; exe_is_load = 1; id_rs_addr = 9; id_rs_used = 1;
    for (int i = 0; i < 20; i++) tick();
    #1;
    chk("sat_stall_cnt", 16'(load_stall_cnt), 16'hf);
    cnt_clr = 1;
    tick();
    cnt_clr = 0; #1;
    chk("sat_clr", 16'(load_stall_cnt), 16'h0);

    // asynchronous reset in the middle of a flush
    clear_pipe();
    redirect = 1;
    tick();
    redirect = 0; #1;
    chk("rfl_in_flush", 16'(rst_v), 16'h08);
    rst = 1; #1;
    chk("rfl_rst_rst", 16'(rst_v), 16'h1f);
    chk("rfl_rst_en", 16'(en_v), 16'h1f);
    rst = 0; #1;
    chk("rfl_back_run", 16'(rst_v), 16'h00);
    chk("rfl_cnt", 16'(flush_cnt), 16'h0);
    tick(); #1;
    chk("rfl_next", 16'(rst_v), 16'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
